// File: rtl/fmap_burst_reader.sv
// fmap_burst_reader: streams a run of consecutive feature-map words out of the
// ping-pong memory as LANES-wide beats over valid/ready. Reads have one cycle
// of latency, so a small beat FIFO holds the returned data. Reads are only
// issued when the FIFO has room for them, so no data is lost under backpressure.
module fmap_burst_reader #(
  parameter int DATA_W     = 16,
  parameter int LANES      = 16,
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [31:0]               num_words,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rden,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [LANES*DATA_W-1:0]   mem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic                      out_last,
  output logic [$clog2(LANES):0]    out_count
);

  localparam int LSH    = $clog2(LANES);
  localparam int IDX_W  = 32 - LSH;
  localparam int CNT_W  = LSH + 1;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int FCW    = PW + 1;
  localparam int BEAT_W = LANES * DATA_W;
  localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  base_r, addr_hold, addr_cur;
  logic [IDX_W-1:0]   last_idx, issue_idx;
  logic [CNT_W-1:0]   tail_cnt;
  logic [31:0]        num_m1;
  logic               issue_last, can_issue;
  logic               vld_p1, last_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               push, pop;
  logic [FCW-1:0]     fifo_count;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [BEAT_W-1:0]  f_data [FIFO_DEPTH];
  logic               f_last [FIFO_DEPTH];
  logic [CNT_W-1:0]   f_cnt  [FIFO_DEPTH];

  // Zero every lane at or beyond the valid-lane count of a tail beat.
  function automatic logic [BEAT_W-1:0] mask_tail(input logic [BEAT_W-1:0] d,
                                                   input logic [CNT_W-1:0]  n);
    logic [BEAT_W-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++)
      if (CNT_W'(i) >= n) r[i*DATA_W +: DATA_W] = '0;
    return r;
  endfunction

  // Last beat index is (num_words-1)/LANES, which always fits the beat counter.
  assign num_m1     = num_words - 32'd1;
  assign addr_cur   = base_r + ADDR_W'({issue_idx, {LSH{1'b0}}});
  assign issue_last = (issue_idx == last_idx);
  assign can_issue  = (fifo_count + FCW'(vld_p1)) < DEPTH_C;
  assign push       = vld_p1;
  assign pop        = out_valid & out_ready;
  assign busy       = (state != IDLE);
  assign mem_addr   = mem_rden ? addr_cur : addr_hold;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, read issue and done pulse.
  always_comb begin
    state_nxt = state;
    mem_rden  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (num_words == 32'd0) ? FIN : ISSUE;
      ISSUE: if (can_issue) begin
               mem_rden = 1'b1;
               if (issue_last) state_nxt = DRAIN;
             end
      DRAIN: if (!vld_p1 && ((fifo_count - FCW'(pop)) == FCW'(0))) state_nxt = FIN;
      FIN:   begin
               done      = 1'b1;
               state_nxt = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  // Transfer descriptor, latched only when a start is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      base_r   <= base_addr;
      last_idx <= num_m1[31:LSH];
      tail_cnt <= CNT_W'(num_m1[LSH-1:0]) + CNT_W'(1);
    end
  end

  // Beat counter, held address and in-flight flag; reset squashes a pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_idx <= '0;
      addr_hold <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= mem_rden;
      if (state == IDLE && start) issue_idx <= '0;
      else if (mem_rden) begin
        issue_idx <= issue_idx + IDX_W'(1);
        addr_hold <= addr_cur;
      end
    end
  end

  // ---- p0 -> p1: beat tag travels alongside the outstanding read ----
  always_ff @(posedge clk) begin
    if (mem_rden) begin
      last_p1 <= issue_last;
      cnt_p1  <= issue_last ? tail_cnt : CNT_W'(LANES);
    end
  end

  // ---- p1 -> FIFO: returned data masked and stored with its tag ----
  always_ff @(posedge clk) begin
    if (push) begin
      f_data[wr_ptr] <= mask_tail(mem_rdata, cnt_p1);
      f_last[wr_ptr] <= last_p1;
      f_cnt[wr_ptr]  <= cnt_p1;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide on a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
    end
  end

  // FIFO head drives the output; everything reads zero while nothing is valid.
  always_comb begin
    out_valid = (fifo_count != FCW'(0));
    out_data  = out_valid ? f_data[rd_ptr] : '0;
    out_last  = out_valid ? f_last[rd_ptr] : 1'b0;
    out_count = out_valid ? f_cnt[rd_ptr]  : '0;
  end

endmodule

// File: tb/tb_fmap_burst_reader.sv
// Scoreboard bench for fmap_burst_reader: directed transfers push expected
// beats and read addresses into queues; a monitor compares what the DUT shows.
module tb_fmap_burst_reader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  num_words = '0;
  logic         busy, done, mem_rden;
  logic [31:0]  mem_addr;
  logic [255:0] mem_rdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [255:0] out_data;
  logic         out_last;
  logic [4:0]   out_count;

  typedef struct {
    logic [255:0] d;
    logic         last;
    logic [4:0]   cnt;
  } beat_t;

  beat_t        sb[$];
  logic [31:0]  aq[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           start_cyc = 0;
  int           hs_cyc = 0;
  int           occ = 0;
  int           done_seen = 0;
  int           expect_done = 0;
  bit           zero_mode = 0;
  bit           first_pending = 0;
  bit           rnd_ready = 0;

  fmap_burst_reader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_at(input logic [31:0] a);
    return a[15:0] ^ 16'h5A00 ^ {a[31:28], 12'h000};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
  end

  // Memory: one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (mem_rden)
      for (int i = 0; i < 16; i++) mem_rdata[i*16 +: 16] <= word_at(mem_addr + 32'(i));
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: issue rule, addresses, beats, stability, latency and done timing.
  initial begin
    bit           prev_stall, last_done, hs;
    logic [255:0] pd;
    logic         pl;
    logic [4:0]   pc;
    beat_t        e;
    logic [31:0]  ea;
    prev_stall = 0; last_done = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        occ = 0; prev_stall = 0; last_done = 0;
      end else begin
        hs = out_valid && out_ready;
        if (mem_rden) begin
          checks++;
          if (occ >= 4) begin failures++; $display("FAIL issue_rule occupancy=%0d required<4", occ); end
          checks++;
          if (aq.size() == 0) begin
            failures++; $display("FAIL rd_addr unexpected read addr=%h", mem_addr);
          end else begin
            ea = aq.pop_front();
            if (mem_addr !== ea) begin failures++; $display("FAIL rd_addr got=%h exp=%h", mem_addr, ea); end
          end
        end
        if (prev_stall) begin
          checks++;
          if (!out_valid || out_data !== pd || out_last !== pl || out_count !== pc) begin
            failures++; $display("FAIL stall_stable valid=%b last=%b/%b count=%0d/%0d", out_valid, out_last, pl, out_count, pc);
          end
        end
        if (out_valid && first_pending) begin
          checks++; first_pending = 0;
          if (cyc != start_cyc + 2) begin failures++; $display("FAIL first_latency got=%0d exp=%0d", cyc - start_cyc, 2); end
        end
        if (hs) begin
          checks++;
          if (sb.size() == 0) begin
            failures++; $display("FAIL beat unexpected beat count=%0d last=%b", out_count, out_last);
          end else begin
            e = sb.pop_front();
            if (out_data !== e.d || out_last !== e.last || out_count !== e.cnt) begin
              failures++;
              $display("FAIL beat got=%h last=%b cnt=%0d exp=%h last=%b cnt=%0d", out_data, out_last, out_count, e.d, e.last, e.cnt);
            end
          end
          if (out_last) hs_cyc = cyc;
        end
        prev_stall = out_valid && !out_ready;
        pd = out_data; pl = out_last; pc = out_count;
        if (done) begin
          checks++; done_seen++;
          if (expect_done == 0) begin
            failures++; $display("FAIL done unexpected pulse at cycle %0d", cyc);
          end else begin
            expect_done--;
            if (zero_mode ? (cyc - start_cyc > 1) : (cyc != hs_cyc + 1)) begin
              failures++; $display("FAIL done_timing got_cycle=%0d start=%0d last_hs=%0d", cyc, start_cyc, hs_cyc);
            end
          end
          checks++;
          if (last_done) begin failures++; $display("FAIL done_width pulse longer than 1 cycle"); end
        end
        last_done = done;
        occ = occ + int'(mem_rden) - int'(hs);
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (busy || done || mem_rden || mem_addr != 0 || out_valid || out_last || out_count != 0 || out_data != 0) begin
      failures++;
      $display("FAIL %s busy=%b done=%b rden=%b addr=%h valid=%b last=%b count=%0d data_nz=%b exp all zero",
               name, busy, done, mem_rden, mem_addr, out_valid, out_last, out_count, |out_data);
    end
  endtask

  task automatic expect_transfer(input logic [31:0] b, input logic [31:0] n);
    int    beats;
    beat_t e;
    logic [31:0] a;
    beats = int'((n + 32'd15) >> 4);
    for (int k = 0; k < beats; k++) begin
      a = b + 32'(16 * k);
      aq.push_back(a);
      e.last = (k == beats - 1);
      e.cnt  = e.last ? 5'(n - 32'(16 * (beats - 1))) : 5'd16;
      e.d    = '0;
      for (int i = 0; i < 16; i++)
        if (i < int'(e.cnt)) e.d[i*16 +: 16] = word_at(a + 32'(i));
      sb.push_back(e);
    end
  endtask

  task automatic run(input logic [31:0] b, input logic [31:0] n, input bit poke);
    int target;
    expect_transfer(b, n);
    expect_done++;
    zero_mode = (n == 0);
    target = done_seen + 1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_words = n;
    @(posedge clk); #1;
    start_cyc = cyc;
    first_pending = (n != 0);
    start = 1'b0; base_addr = 32'hDEAD0000; num_words = 32'd7;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; base_addr = 32'h5000; num_words = 32'd16;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int t = 0; t < 500 && done_seen < target; t++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (done_seen < target) begin failures++; $display("FAIL done_timeout base=%h n=%0d", b, n); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || aq.size() != 0) begin
      failures++; $display("FAIL drained beats_left=%0d addrs_left=%0d exp 0", sb.size(), aq.size());
    end
    first_pending = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check_zero("reset_state");

    run(32'h0000_0100, 32'd32, 1'b1);   // two full beats, start while busy ignored
    run(32'h0000_0400, 32'd20, 1'b0);   // tail beat of 4 lanes
    rnd_ready = 1;
    run(32'h0000_1000, 32'd160, 1'b0);  // backpressure, 10 beats
    run(32'h0000_2008, 32'd37, 1'b0);   // tail of 5 under backpressure
    rnd_ready = 0;
    run(32'h0000_3000, 32'd0, 1'b0);    // empty transfer
    run(32'hFFFF_FFF0, 32'd48, 1'b0);   // address wrap
    run(32'h0000_0500, 32'd1, 1'b0);    // single word

    // Abort a 64-word transfer right after its first read is issued.
    aq.push_back(32'h0000_0200);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h0000_0200; num_words = 32'd64;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check_zero("abort_outputs");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check_zero("abort_quiet");
    checks++;
    if (aq.size() != 0) begin failures++; $display("FAIL abort_first_read addrs_left=%0d exp 0", aq.size()); end
    run(32'h0000_0600, 32'd16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
